adc_deser_array: RTL and testbench

Parametrised multi-channel deserializer for AD4003-family SAR ADCs on the ATCA-K26 carrier; successor to the fixed 18-bit ADC block. It samples two single-ended SDO lanes (A, B) per channel in the delayed `adc_read_clk` domain and assembles a word per lane on each conversion. It adds a capture state machine, a per-channel enable mask, a frame counter, overrun detection and an optional test-pattern mode. It sits after the board-level LVDS input buffers, which live in the top-level wrapper, and feeds the acquisition/DMA packer.

---
 rtl/adc_deser_array_if.sv | 31 +++
 rtl/adc_deser_array.sv | 157 +++++++++++++++
 tb/tb_adc_deser_array.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_deser_array_if.sv
// Bus between the AD4003 deserializer array and its controller/consumer.
// Carries trigger, channel mask, SDO lanes and the captured-frame outputs.
interface adc_deser_array_if #(
   parameter int ADC_CHANNELS    = 4,
   parameter int ADC_DATA_WIDTH  = 18,
   parameter int FRAME_CNT_WIDTH = 16
);
   // data_valid is a one-cycle strobe with no back-pressure: the consumer
   // must take adc_a_data_arr/adc_b_data_arr in the cycle data_valid is high.
   logic                                   reader_en_sync;
   logic [ADC_CHANNELS-1:0]                ch_en;
   logic                                   clr_overrun;
   logic [ADC_CHANNELS-1:0]                adc_sdo_cha;
   logic [ADC_CHANNELS-1:0]                adc_sdo_chb;
   logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_a_data_arr;
   logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_b_data_arr;
   logic                                   data_valid;
   logic [FRAME_CNT_WIDTH-1:0]             frame_cnt;
   logic                                   busy;
   logic                                   overrun;

   modport master (
      output reader_en_sync, ch_en, clr_overrun, adc_sdo_cha, adc_sdo_chb,
      input  adc_a_data_arr, adc_b_data_arr, data_valid, frame_cnt, busy, overrun
   );

   modport slave (
      input  reader_en_sync, ch_en, clr_overrun, adc_sdo_cha, adc_sdo_chb,
      output adc_a_data_arr, adc_b_data_arr, data_valid, frame_cnt, busy, overrun
   );
endinterface

// File: rtl/adc_deser_array.sv
// Multi-channel two-lane SAR ADC deserializer with capture FSM, channel mask,
// frame counter and overrun flag. Optional test pattern: ADC_TEST_PATTERN_EN.
module adc_deser_array #(
   parameter int ADC_CHANNELS    = 4,
   parameter int ADC_DATA_WIDTH  = 18,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic       adc_read_clk,
   input  logic       rst_n,
`ifdef ADC_TEST_PATTERN_EN
   input  logic       test_mode,
`endif
   output logic [1:0] fsm_state,
   adc_deser_array_if.slave bus
);
   localparam int W     = ADC_DATA_WIDTH;
   localparam int CH    = ADC_CHANNELS;
   localparam int CNT_W = $clog2(W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);

   logic [1:0]                 state;
   logic                       rsync_q;
   logic                       armed;
   logic                       trig;
   logic [CNT_W-1:0]           bit_cnt;
   logic [CH-1:0]              ch_en_q;
   logic [W*CH-1:0]            sh_a;
   logic [W*CH-1:0]            sh_b;
   logic [W*CH-1:0]            load_a;
   logic [W*CH-1:0]            load_b;
   logic [W*CH-1:0]            a_arr;
   logic [W*CH-1:0]            b_arr;
   logic                       dv;
   logic [FRAME_CNT_WIDTH-1:0] fcnt;
   logic                       ovr;
`ifdef ADC_TEST_PATTERN_EN
   logic                       test_mode_q;
`endif

   // armed blocks a level that is still high after reset from looking like
   // a fresh rising edge; it sets once the trigger has been seen low.
   assign trig = bus.reader_en_sync & ~rsync_q & armed;

   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         rsync_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         rsync_q <= bus.reader_en_sync;
         if (!bus.reader_en_sync) armed <= 1'b1;
      end
   end

   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         ch_en_q <= '0;
`ifdef ADC_TEST_PATTERN_EN
         test_mode_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  ch_en_q <= bus.ch_en;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
`ifdef ADC_TEST_PATTERN_EN
                  test_mode_q <= test_mode;
`endif
               end
            end
            ST_SHIFT: begin
               if (bit_cnt == BIT_LAST) state <= ST_LATCH;
               else bit_cnt <= bit_cnt + 1'b1;
            end
            ST_LATCH: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Lanes arrive MSB first, so each sample enters at the LSB.
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a <= '0;
         sh_b <= '0;
      end else if (state == ST_SHIFT) begin
         for (int k = 0; k < CH; k++) begin
            sh_a[W*k +: W] <= {sh_a[W*k +: W-1], bus.adc_sdo_cha[k]};
            sh_b[W*k +: W] <= {sh_b[W*k +: W-1], bus.adc_sdo_chb[k]};
         end
      end
   end

   always_comb begin
      load_a = '0;
      load_b = '0;
      for (int k = 0; k < CH; k++) begin
         if (ch_en_q[k]) begin
`ifdef ADC_TEST_PATTERN_EN
            if (test_mode_q) begin
               load_a[W*k +: W] = W'(fcnt) + W'(k);
               load_b[W*k +: W] = ~(W'(fcnt) + W'(k));
            end else begin
               load_a[W*k +: W] = sh_a[W*k +: W];
               load_b[W*k +: W] = sh_b[W*k +: W];
            end
`else
            load_a[W*k +: W] = sh_a[W*k +: W];
            load_b[W*k +: W] = sh_b[W*k +: W];
`endif
         end
      end
   end

   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         a_arr <= '0;
         b_arr <= '0;
         dv    <= 1'b0;
         fcnt  <= '0;
      end else begin
         dv <= (state == ST_LATCH);
         if (state == ST_LATCH) begin
            a_arr <= load_a;
            b_arr <= load_b;
            fcnt  <= fcnt + 1'b1;
         end
      end
   end

   // A trigger that arrives while a frame is in flight is dropped; set beats clear.
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr <= 1'b0;
      end else if (trig && (state != ST_IDLE)) begin
         ovr <= 1'b1;
      end else if (bus.clr_overrun) begin
         ovr <= 1'b0;
      end
   end

   assign bus.adc_a_data_arr = a_arr;
   assign bus.adc_b_data_arr = b_arr;
   assign bus.data_valid     = dv;
   assign bus.frame_cnt      = fcnt;
   assign bus.busy           = (state != ST_IDLE);
   assign bus.overrun        = ovr;
   assign fsm_state          = state;
endmodule

// File: tb/tb_adc_deser_array.sv
// Self-checking bench for adc_deser_array: table-driven frames, a scoreboard
// fed at trigger time, and hand sequences for overrun, hold, reset and wrap.
module tb_adc_deser_array;
   localparam int CH  = 4;
   localparam int W   = 18;
   localparam int FCW = 8;
   localparam int AW  = W * CH;
   localparam int EW  = 2 * AW + FCW;

   typedef struct {
      logic [CH-1:0] en;
      logic [AW-1:0] a_in;
      logic [AW-1:0] b_in;
      logic [AW-1:0] a_exp;
      logic [AW-1:0] b_exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] fsm_state;
`ifdef ADC_TEST_PATTERN_EN
   logic       test_mode;
`endif

   adc_deser_array_if #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .FRAME_CNT_WIDTH(FCW)) bus ();

   adc_deser_array #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .FRAME_CNT_WIDTH(FCW)) dut (
      .adc_read_clk (clk),
      .rst_n        (rst_n),
`ifdef ADC_TEST_PATTERN_EN
      .test_mode    (test_mode),
`endif
      .fsm_state    (fsm_state),
      .bus          (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_pass  = 0;
   int            n_total = 0;
   logic [EW-1:0] exp_q[$];
   logic [FCW-1:0] exp_fc = '0;
   vec_t          vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] mask(input logic [AW-1:0] d, input logic [CH-1:0] en);
      logic [AW-1:0] r;
      r = d;
      for (int k = 0; k < CH; k++) if (!en[k]) r[W*k +: W] = '0;
      return r;
   endfunction

   // scoreboard: pop one expected frame per data_valid strobe
   always @(negedge clk) begin
      if (rst_n && bus.data_valid) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL dv_unexpected: got data_valid=1 expected 0 (no frame pending) t=%0t", $time);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("sb_lane_a", 128'(bus.adc_a_data_arr), 128'(e[EW-1 -: AW]));
            check("sb_lane_b", 128'(bus.adc_b_data_arr), 128'(e[AW+FCW-1 -: AW]));
            check("sb_frame_cnt", 128'(bus.frame_cnt), 128'(e[FCW-1:0]));
         end
      end
   end

   // driver: one full frame from trigger edge T0 through TW+1
   task automatic run_frame(input logic [AW-1:0] a_in, input logic [AW-1:0] b_in,
                            input logic [CH-1:0] en, input logic [AW-1:0] a_exp,
                            input logic [AW-1:0] b_exp, input bit retrig, input bit hold);
      bus.reader_en_sync = 1'b1;
      bus.ch_en          = en;
      exp_fc             = exp_fc + 1'b1;
      exp_q.push_back({a_exp, b_exp, exp_fc});
      step();
      bus.ch_en = ~en;
      for (int n = 1; n <= W; n++) begin
         for (int k = 0; k < CH; k++) begin
            bus.adc_sdo_cha[k] = a_in[W*k + W - n];
            bus.adc_sdo_chb[k] = b_in[W*k + W - n];
         end
         bus.reader_en_sync = hold | (retrig && n >= 10);
         bus.clr_overrun    = retrig && (n == 10);
         step();
         if (n == 1) check("busy_shift", 128'(bus.busy), 128'(1));
         if (n == W) begin
            check("dv_early", 128'(bus.data_valid), 128'(0));
            check("fsm_latch", 128'(fsm_state), 128'(2));
         end
      end
      bus.clr_overrun    = 1'b0;
      bus.reader_en_sync = hold;
      bus.adc_sdo_cha    = CH'($urandom_range(0, (1 << CH) - 1));
      bus.adc_sdo_chb    = CH'($urandom_range(0, (1 << CH) - 1));
      step();
      check("dv_latency", 128'(bus.data_valid), 128'(1));
      check("busy_after", 128'(bus.busy), 128'(0));
   endtask

   initial begin
      logic [AW-1:0] pat_a;
      logic [AW-1:0] hold_exp;

      vecs[0] = '{4'hF, {18'h11111, 18'h0ABCD, 18'h3C3C3, 18'h2A5A3},
                        {18'h22222, 18'h01234, 18'h3FFFF, 18'h15A5C},
                        {18'h11111, 18'h0ABCD, 18'h3C3C3, 18'h2A5A3},
                        {18'h22222, 18'h01234, 18'h3FFFF, 18'h15A5C}};
      vecs[1] = '{4'b0101, {AW{1'b1}}, {AW{1'b1}},
                  {18'h0, 18'h3FFFF, 18'h0, 18'h3FFFF},
                  {18'h0, 18'h3FFFF, 18'h0, 18'h3FFFF}};
      vecs[2] = '{4'b0000, {4{18'h2AAAA}}, {4{18'h15555}}, '0, '0};
      vecs[3] = '{4'b1000, {18'h00001, 18'h3FFFE, 18'h20000, 18'h1FFFF},
                           {18'h3FFFF, 18'h00100, 18'h00002, 18'h10001},
                           {18'h00001, 54'h0}, {18'h3FFFF, 54'h0}};
      for (int i = 4; i < 6; i++) begin
         vecs[i].en = CH'($urandom_range(0, (1 << CH) - 1));
         for (int k = 0; k < CH; k++) begin
            vecs[i].a_in[W*k +: W] = W'($urandom_range(0, (1 << W) - 1));
            vecs[i].b_in[W*k +: W] = W'($urandom_range(0, (1 << W) - 1));
         end
         vecs[i].a_exp = mask(vecs[i].a_in, vecs[i].en);
         vecs[i].b_exp = mask(vecs[i].b_in, vecs[i].en);
      end

      rst_n              = 1'b0;
      bus.reader_en_sync = 1'b0;
      bus.ch_en          = '0;
      bus.clr_overrun    = 1'b0;
      bus.adc_sdo_cha    = '0;
      bus.adc_sdo_chb    = '0;
`ifdef ADC_TEST_PATTERN_EN
      test_mode          = 1'b0;
`endif
      step();
      step();
      check("rst_a_arr", 128'(bus.adc_a_data_arr), 128'(0));
      check("rst_b_arr", 128'(bus.adc_b_data_arr), 128'(0));
      check("rst_dv", 128'(bus.data_valid), 128'(0));
      check("rst_fc", 128'(bus.frame_cnt), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_overrun", 128'(bus.overrun), 128'(0));
      check("rst_fsm", 128'(fsm_state), 128'(0));
      rst_n = 1'b1;
      step();
      step();

      // table frames, issued at the minimum trigger period
      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].a_in, vecs[i].b_in, vecs[i].en, vecs[i].a_exp, vecs[i].b_exp, 0, 0);
      check("min_period_no_overrun", 128'(bus.overrun), 128'(0));

      // second edge at T10 with a coincident clear: set wins, frame intact
      run_frame(vecs[0].a_in, vecs[0].b_in, 4'hF, vecs[0].a_exp, vecs[0].b_exp, 1, 0);
      check("overrun_set", 128'(bus.overrun), 128'(1));
      repeat (W + 5) step();
      check("overrun_sticky", 128'(bus.overrun), 128'(1));
      bus.clr_overrun = 1'b1;
      step();
      bus.clr_overrun = 1'b0;
      check("overrun_clr", 128'(bus.overrun), 128'(0));

      // level held high for 3W cycles captures one frame only
      hold_exp = mask(vecs[4].a_in, 4'b0110);
      run_frame(vecs[4].a_in, vecs[4].b_in, 4'b0110, hold_exp, mask(vecs[4].b_in, 4'b0110), 0, 1);
      repeat (2 * W) step();
      check("hold_no_overrun", 128'(bus.overrun), 128'(0));
      check("hold_arrays", 128'(bus.adc_a_data_arr), 128'(hold_exp));
      bus.reader_en_sync = 1'b0;
      step();

      // reset at T8 of a frame, trigger left high afterwards
      bus.reader_en_sync = 1'b1;
      bus.ch_en          = 4'hF;
      bus.adc_sdo_cha    = 4'hF;
      bus.adc_sdo_chb    = 4'hF;
      step();
      repeat (8) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3 * W) step();
      check("rst_mid_a_arr", 128'(bus.adc_a_data_arr), 128'(0));
      check("rst_mid_b_arr", 128'(bus.adc_b_data_arr), 128'(0));
      check("rst_mid_fc", 128'(bus.frame_cnt), 128'(0));
      check("rst_mid_busy", 128'(bus.busy), 128'(0));
      check("rst_mid_dv", 128'(bus.data_valid), 128'(0));
      check("rst_mid_fsm", 128'(fsm_state), 128'(0));
      exp_fc             = '0;
      bus.reader_en_sync = 1'b0;
      step();

      // frame counter wrap
      for (int i = 0; i < (1 << FCW) - 1; i++) run_frame('0, '0, 4'hF, '0, '0, 0, 0);
      check("fc_all_ones", 128'(bus.frame_cnt), 128'({FCW{1'b1}}));
      run_frame('0, '0, 4'hF, '0, '0, 0, 0);
      check("fc_wrap", 128'(bus.frame_cnt), 128'(0));
      check("wrap_no_overrun", 128'(bus.overrun), 128'(0));

`ifdef ADC_TEST_PATTERN_EN
      for (int i = 0; i < 5; i++) run_frame('0, '0, 4'hF, '0, '0, 0, 0);
      pat_a = {18'h00008, 18'h00007, 18'h00006, 18'h00005};
      test_mode = 1'b1;
      run_frame(vecs[5].a_in, vecs[5].b_in, 4'hF, pat_a, ~pat_a, 0, 0);
      test_mode = 1'b0;
      check("tp_ch3_a", 128'(bus.adc_a_data_arr[71:54]), 128'(18'h00008));
      check("tp_ch3_b", 128'(bus.adc_b_data_arr[71:54]), 128'(18'h3FFF7));
`else
      pat_a = '0;
      check("tp_absent_arr", 128'(bus.adc_a_data_arr), 128'(pat_a));
`endif

      repeat (4) step();
      check("sb_drained", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
